// File: rtl/eth_prbs_checker_multi.sv
// Self-synchronising PRBS7/9/15/23/31 checker with lock tracking and a saturating bit-error count.
// The expected bits come from the received stream itself, so no seed has to be acquired.
module eth_prbs_checker_multi #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ERR_CNT_WIDTH = 32,
  parameter int unsigned LOCK_CNT      = 16,
  parameter int unsigned UNLOCK_WIN    = 64,
  parameter int unsigned UNLOCK_ERRS   = 16,
  parameter bit          INVERT        = 1'b0,
  localparam int unsigned BitsW        = $clog2(DATA_WIDTH + 1)
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst,
  input  logic                     cfg_enable,
  input  logic [2:0]               cfg_mode,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid,
  input  logic                     cnt_clear,
  output logic                     prbs_lock,
  output logic                     err_word,
  output logic [BitsW-1:0]         err_bits,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  localparam int unsigned CleanW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WinW   = $clog2(UNLOCK_WIN + 1);
  localparam int unsigned ErrwW  = $clog2(UNLOCK_ERRS + 1);
  localparam int unsigned SumW   = ((ERR_CNT_WIDTH > BitsW) ? ERR_CNT_WIDTH : BitsW) + 1;
  localparam int unsigned Fill7  = (7 + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned Fill9  = (9 + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned Fill15 = (15 + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned Fill23 = (23 + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int unsigned Fill31 = (31 + DATA_WIDTH - 1) / DATA_WIDTH;

  typedef enum logic [1:0] {StDisabled, StHunt, StLocked} state_e;

  state_e                   state_q, state_d;
  logic [30:0]              hist_q, hist_d;
  logic [2:0]               mode_q;
  logic                     en_q;
  logic [2:0]               fill_q, fill_d;
  logic [CleanW-1:0]        clean_q, clean_d;
  logic [WinW-1:0]          win_q, win_d;
  logic [ErrwW-1:0]         errw_q, errw_d;
  logic                     lock_q, lock_d;
  logic                     err_word_q, err_word_d;
  logic [BitsW-1:0]         err_bits_q, err_bits_d;
  logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;

  logic [2:0]               mode_eff;
  logic                     restart;
  logic [DATA_WIDTH-1:0]    data_in;
  logic [30:0]              hist_base;
  logic [DATA_WIDTH+30:0]   ext;
  logic [DATA_WIDTH-1:0]    exp7, exp9, exp15, exp23, exp31, exp_vec, err_vec;
  logic [2:0]               fill_need;
  logic [BitsW-1:0]         pop;
  logic [SumW-1:0]          sum;

  assign mode_eff  = (cfg_mode > 3'd4) ? 3'd4 : cfg_mode;
  assign restart   = cfg_enable && (!en_q || (mode_eff != mode_q));
  assign data_in   = INVERT ? ~rx_data : rx_data;
  // A restarted word sees an empty history; it is a fill word anyway.
  assign hist_base = restart ? '0 : hist_q;
  // ext[0] is the oldest history bit, ext[31+n] is word bit n.
  assign ext       = {data_in, hist_base};

  always_comb begin
    for (int n = 0; n < DATA_WIDTH; n++) begin
      exp7[n]  = ext[n + 24] ^ ext[n + 25];
      exp9[n]  = ext[n + 22] ^ ext[n + 26];
      exp15[n] = ext[n + 16] ^ ext[n + 17];
      exp23[n] = ext[n + 8]  ^ ext[n + 13];
      exp31[n] = ext[n]      ^ ext[n + 3];
    end
  end

  always_comb begin
    case (mode_eff)
      3'd0:    begin exp_vec = exp7;  fill_need = 3'(Fill7);  end
      3'd1:    begin exp_vec = exp9;  fill_need = 3'(Fill9);  end
      3'd2:    begin exp_vec = exp15; fill_need = 3'(Fill15); end
      3'd3:    begin exp_vec = exp23; fill_need = 3'(Fill23); end
      default: begin exp_vec = exp31; fill_need = 3'(Fill31); end
    endcase
  end

  assign err_vec = data_in ^ exp_vec;

  always_comb begin
    pop = '0;
    for (int n = 0; n < DATA_WIDTH; n++) begin
      pop = pop + BitsW'(err_vec[n]);
    end
  end

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    clean_d     = clean_q;
    win_d       = win_q;
    errw_d      = errw_q;
    lock_d      = lock_q;
    err_word_d  = 1'b0;
    err_bits_d  = '0;
    err_count_d = err_count_q;
    sum         = SumW'(err_count_q) + SumW'(pop);

    if (!cfg_enable) begin
      state_d = StDisabled;
      lock_d  = 1'b0;
    end else begin
      if (restart) begin
        state_d = StHunt;
        lock_d  = 1'b0;
        hist_d  = '0;
        fill_d  = '0;
        clean_d = '0;
        win_d   = '0;
        errw_d  = '0;
      end
      if (rx_valid) begin
        hist_d = ext[DATA_WIDTH +: 31];
        if (fill_d < fill_need) begin
          fill_d = fill_d + 3'd1;
        end else begin
          err_word_d = |err_vec;
          err_bits_d = pop;
          case (state_d)
            StHunt: begin
              if (|err_vec) begin
                clean_d = '0;
              end else if (|ext) begin
                clean_d = clean_d + CleanW'(1);
                if (clean_d == CleanW'(LOCK_CNT)) begin
                  state_d = StLocked;
                  lock_d  = 1'b1;
                  clean_d = '0;
                  win_d   = '0;
                  errw_d  = '0;
                end
              end
            end
            StLocked: begin
              if (sum > SumW'({ERR_CNT_WIDTH{1'b1}})) err_count_d = '1;
              else                                    err_count_d = sum[ERR_CNT_WIDTH-1:0];
              win_d  = win_d + WinW'(1);
              errw_d = errw_d + ErrwW'(err_word_d);
              if (errw_d == ErrwW'(UNLOCK_ERRS)) begin
                state_d = StHunt;
                lock_d  = 1'b0;
                win_d   = '0;
                errw_d  = '0;
              end else if (win_d == WinW'(UNLOCK_WIN)) begin
                win_d  = '0;
                errw_d = '0;
              end
            end
            default: ;
          endcase
        end
      end
    end

    if (cnt_clear) err_count_d = '0;
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q     <= StHunt;
      hist_q      <= '0;
      mode_q      <= '0;
      en_q        <= 1'b0;
      fill_q      <= '0;
      clean_q     <= '0;
      win_q       <= '0;
      errw_q      <= '0;
      lock_q      <= 1'b0;
      err_word_q  <= 1'b0;
      err_bits_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      mode_q      <= mode_eff;
      en_q        <= cfg_enable;
      fill_q      <= fill_d;
      clean_q     <= clean_d;
      win_q       <= win_d;
      errw_q      <= errw_d;
      lock_q      <= lock_d;
      err_word_q  <= err_word_d;
      err_bits_q  <= err_bits_d;
      err_count_q <= err_count_d;
    end
  end

  assign prbs_lock = lock_q;
  assign err_word  = err_word_q;
  assign err_bits  = err_bits_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_eth_prbs_checker_multi.sv
// Directed bench for eth_prbs_checker_multi at W=64 with a 4-bit error counter.
// Reference PRBS streams come from a bench-side generator.
module tb_eth_prbs_checker_multi;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic        cfg_enable;
  logic [2:0]  cfg_mode;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        cnt_clear;
  logic        prbs_lock;
  logic        err_word;
  logic [6:0]  err_bits;
  logic [3:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [30:0] g;
  int          ga, gb;

  eth_prbs_checker_multi #(
    .DATA_WIDTH   (64),
    .ERR_CNT_WIDTH(4),
    .LOCK_CNT     (16),
    .UNLOCK_WIN   (64),
    .UNLOCK_ERRS  (16),
    .INVERT       (1'b0)
  ) dut (
    .rx_clk    (rx_clk),
    .rx_rst    (rx_rst),
    .cfg_enable(cfg_enable),
    .cfg_mode  (cfg_mode),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cnt_clear (cnt_clear),
    .prbs_lock (prbs_lock),
    .err_word  (err_word),
    .err_bits  (err_bits),
    .err_count (err_count)
  );

  always #5 rx_clk = ~rx_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the edge that consumed the word.
  task automatic step(input logic [63:0] d, input logic v);
    rx_data  = d;
    rx_valid = v;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic set_gen(input int mode);
    case (mode)
      0:       begin ga = 7;  gb = 6;  end
      1:       begin ga = 9;  gb = 5;  end
      2:       begin ga = 15; gb = 14; end
      3:       begin ga = 23; gb = 18; end
      default: begin ga = 31; gb = 28; end
    endcase
    g = '1;
  endtask

  // g[0] is the newest bit; d[n] = d[n-a] ^ d[n-b]; word bit 0 goes first.
  task automatic gen_word(output logic [63:0] w);
    logic nb;
    for (int n = 0; n < 64; n++) begin
      nb   = g[ga-1] ^ g[gb-1];
      g    = {g[29:0], nb};
      w[n] = nb;
    end
  endtask

  // One fill word plus 16 clean words: lock appears after the 17th word.
  task automatic relock(input string tag);
    logic [63:0] w;
    for (int i = 0; i < 16; i++) begin
      gen_word(w);
      step(w, 1'b1);
    end
    chk({tag, "_pre"}, 64'(prbs_lock), 64'd0);
    gen_word(w);
    step(w, 1'b1);
    chk(tag, 64'(prbs_lock), 64'd1);
  endtask

  initial begin
    logic [63:0] w;
    logic        seen;

    rx_rst     = 1'b1;
    cfg_enable = 1'b1;
    cfg_mode   = 3'd4;
    rx_data    = '0;
    rx_valid   = 1'b0;
    cnt_clear  = 1'b0;
    set_gen(4);
    repeat (2) @(posedge rx_clk);
    #1;
    chk("rst_lock", 64'(prbs_lock), 64'd0);
    chk("rst_err_word", 64'(err_word), 64'd0);
    chk("rst_err_bits", 64'(err_bits), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    rx_rst = 1'b0;
    step('0, 1'b0);

    // Clean PRBS31 lock.
    relock("t1_lock");
    chk("t1_count", 64'(err_count), 64'd0);

    // Unrelated random data while freshly locked.
    for (int i = 0; i < 15; i++) step({$urandom, $urandom}, 1'b1);
    chk("t3_garbage15_lock", 64'(prbs_lock), 64'd1);
    step({$urandom, $urandom}, 1'b1);
    chk("t3_garbage16_unlock", 64'(prbs_lock), 64'd0);
    chk("t3_garbage_err_word", 64'(err_word), 64'd1);
    chk("t5_saturated", 64'(err_count), 64'd15);

    cnt_clear = 1'b1;
    step('0, 1'b0);
    cnt_clear = 1'b0;
    chk("t5_clear_idle", 64'(err_count), 64'd0);
    chk("idle_err_word", 64'(err_word), 64'd0);

    rx_rst = 1'b1;
    step('0, 1'b0);
    rx_rst = 1'b0;
    relock("relock_after_rst");

    // Single bit flips while locked.
    gen_word(w);
    w[5] = ~w[5];
    step(w, 1'b1);
    chk("t2_flip5_word", 64'(err_word), 64'd1);
    chk("t2_flip5_bits", 64'(err_bits), 64'd3);
    chk("t2_flip5_count", 64'(err_count), 64'd3);
    gen_word(w);
    step(w, 1'b1);
    chk("t2_clean_word", 64'(err_word), 64'd0);
    chk("t2_clean_bits", 64'(err_bits), 64'd0);
    gen_word(w);
    w[40] = ~w[40];
    step(w, 1'b1);
    chk("t2_flip40_bits", 64'(err_bits), 64'd1);
    chk("t2_flip40_count", 64'(err_count), 64'd4);
    gen_word(w);
    step(w, 1'b1);
    chk("t2_spill_bits", 64'(err_bits), 64'd2);
    chk("t2_spill_count", 64'(err_count), 64'd6);
    chk("t2_lock_held", 64'(prbs_lock), 64'd1);

    // Clear wins over an increment; then drive to saturation.
    gen_word(w);
    w[5] = ~w[5];
    cnt_clear = 1'b1;
    step(w, 1'b1);
    cnt_clear = 1'b0;
    chk("t5_clear_same_cycle", 64'(err_count), 64'd0);
    chk("t5_clear_err_word", 64'(err_word), 64'd1);
    for (int i = 0; i < 6; i++) begin
      gen_word(w);
      w[5] = ~w[5];
      step(w, 1'b1);
    end
    chk("t5_sat_hold", 64'(err_count), 64'd15);
    chk("t5_sat_lock", 64'(prbs_lock), 64'd1);
    cnt_clear = 1'b1;
    step('0, 1'b0);
    cnt_clear = 1'b0;
    chk("t5_clear_keeps_lock", 64'(prbs_lock), 64'd1);
    chk("t5_cleared", 64'(err_count), 64'd0);

    // Disruptions while locked.
    cfg_enable = 1'b0;
    step({$urandom, $urandom}, 1'b1);
    chk("t6_disable_lock", 64'(prbs_lock), 64'd0);
    chk("t6_disable_err_word", 64'(err_word), 64'd0);
    chk("t6_disable_err_bits", 64'(err_bits), 64'd0);
    cfg_enable = 1'b1;
    relock("t6_relock_enable");

    cfg_mode = 3'd0;
    gen_word(w);
    step(w, 1'b1);
    chk("t6_mode_change_lock", 64'(prbs_lock), 64'd0);
    cfg_mode = 3'd4;
    relock("t6_relock_mode");

    rx_rst = 1'b1;
    gen_word(w);
    step(w, 1'b1);
    chk("t6_rst_lock", 64'(prbs_lock), 64'd0);
    rx_rst = 1'b0;
    relock("t6_relock_rst");

    // Each mode locks on its own stream.
    for (int m = 0; m < 4; m++) begin
      cfg_mode = 3'(m);
      set_gen(m);
      relock($sformatf("t4_mode%0d", m));
    end

    // PRBS7 data checked as PRBS31 must never lock.
    cfg_mode = 3'd4;
    set_gen(0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      gen_word(w);
      step(w, 1'b1);
      if (prbs_lock) seen = 1'b1;
    end
    chk("t4_mismatch_no_lock", 64'(seen), 64'd0);

    // All-zero stream must never lock.
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step('0, 1'b1);
      if (prbs_lock) seen = 1'b1;
    end
    chk("t3_zero_no_lock", 64'(seen), 64'd0);
    chk("t3_zero_err_word", 64'(err_word), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
